// File: rtl/ddr_cmd_arbiter.sv
// DDR4 command-bus arbiter: fixed-priority grant of REF/PRE/CAS/ACT with
// inter-command timing (tRRD, tFAW, tCCD, tWTR, read-to-write) enforced here.
module ddr_cmd_arbiter #(
    parameter int unsigned T_RRD = 4,
    parameter int unsigned T_FAW = 16,
    parameter int unsigned T_CCD = 4,
    parameter int unsigned T_WTR = 8,
    parameter int unsigned T_RTW = 10
) (
    input  logic       clock_t,
    input  logic       reset_n,
    input  logic       ref_req,
    input  logic       pre_req,
    input  logic       cas_req,
    input  logic [1:0] cas_rw,
    input  logic       act_req,
    output logic       ref_gnt,
    output logic       pre_gnt,
    output logic       cas_gnt,
    output logic       act_gnt,
    output logic       cmd_valid,
    output logic [2:0] cmd_code,
    output logic [2:0] faw_count,
    output logic       busy
);

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4,
        CMD_REF = 3'd5
    } cmd_e;

    localparam logic [5:0] RRD_LD = 6'(T_RRD - 1);
    localparam logic [5:0] CCD_LD = 6'(T_CCD - 1);
    localparam logic [5:0] WTR_LD = 6'(T_WTR - 1);
    localparam logic [5:0] RTW_LD = 6'(T_RTW - 1);

    // Handshake: a requester holds req until it observes its gnt (high for
    // exactly one cycle); the registered gnt doubles as a one-cycle mask so
    // a req still high during its own grant cycle is not granted again.
    logic       ref_gnt_q, pre_gnt_q, cas_gnt_q, act_gnt_q;
    logic       ref_gnt_d, pre_gnt_d, cas_gnt_d, act_gnt_d;
    cmd_e       code_q, code_d;
    logic [5:0] rrd_q, rrd_d;
    logic [5:0] ccd_q, ccd_d;
    logic [5:0] wtr_q, wtr_d;
    logic [5:0] rtw_q, rtw_d;
    logic [T_FAW-1:0] faw_q, faw_d;
    logic [2:0] faw_cnt_q, faw_cnt_d;
    logic       busy_q, busy_d;

    logic       cas_rd, cas_wr;
    logic       act_ok, rd_ok, wr_ok;
    logic [2:0] faw_keep;

    function automatic logic [5:0] dec_sat(input logic [5:0] v);
        return (v == 6'd0) ? 6'd0 : v - 6'd1;
    endfunction

    // ACTs that will still sit in the window once the oldest bit shifts out.
    assign faw_keep = faw_cnt_q - {2'b00, faw_q[T_FAW-1]};

    always_comb begin
        cas_rd    = (cas_rw == 2'b01);
        cas_wr    = (cas_rw == 2'b10);
        act_ok    = (rrd_q == 6'd0) && (faw_keep < 3'd4);
        rd_ok     = cas_rd && (ccd_q == 6'd0) && (wtr_q == 6'd0);
        wr_ok     = cas_wr && (ccd_q == 6'd0) && (rtw_q == 6'd0);

        ref_gnt_d = 1'b0;
        pre_gnt_d = 1'b0;
        cas_gnt_d = 1'b0;
        act_gnt_d = 1'b0;
        code_d    = CMD_NOP;

        if (ref_req && !ref_gnt_q) begin
            ref_gnt_d = 1'b1;
            code_d    = CMD_REF;
        end else if (pre_req && !pre_gnt_q) begin
            pre_gnt_d = 1'b1;
            code_d    = CMD_PRE;
        end else if (cas_req && !cas_gnt_q && (rd_ok || wr_ok)) begin
            cas_gnt_d = 1'b1;
            code_d    = rd_ok ? CMD_RD : CMD_WR;
        end else if (act_req && !act_gnt_q && act_ok) begin
            act_gnt_d = 1'b1;
            code_d    = CMD_ACT;
        end
    end

    always_comb begin
        rrd_d     = act_gnt_d ? RRD_LD : dec_sat(rrd_q);
        ccd_d     = cas_gnt_d ? CCD_LD : dec_sat(ccd_q);
        wtr_d     = (cas_gnt_d && code_d == CMD_WR) ? WTR_LD : dec_sat(wtr_q);
        rtw_d     = (cas_gnt_d && code_d == CMD_RD) ? RTW_LD : dec_sat(rtw_q);
        faw_d     = {faw_q[T_FAW-2:0], act_gnt_d};
        faw_cnt_d = faw_keep + {2'b00, act_gnt_d};
        busy_d    = (rrd_d != 6'd0) || (ccd_d != 6'd0) || (wtr_d != 6'd0) ||
                    (rtw_d != 6'd0) || (faw_cnt_d != 3'd0);
    end

    always_ff @(posedge clock_t or negedge reset_n) begin
        if (!reset_n) begin
            ref_gnt_q <= 1'b0;
            pre_gnt_q <= 1'b0;
            cas_gnt_q <= 1'b0;
            act_gnt_q <= 1'b0;
            code_q    <= CMD_NOP;
            rrd_q     <= 6'd0;
            ccd_q     <= 6'd0;
            wtr_q     <= 6'd0;
            rtw_q     <= 6'd0;
            faw_q     <= '0;
            faw_cnt_q <= 3'd0;
            busy_q    <= 1'b0;
        end else begin
            ref_gnt_q <= ref_gnt_d;
            pre_gnt_q <= pre_gnt_d;
            cas_gnt_q <= cas_gnt_d;
            act_gnt_q <= act_gnt_d;
            code_q    <= code_d;
            rrd_q     <= rrd_d;
            ccd_q     <= ccd_d;
            wtr_q     <= wtr_d;
            rtw_q     <= rtw_d;
            faw_q     <= faw_d;
            faw_cnt_q <= faw_cnt_d;
            busy_q    <= busy_d;
        end
    end

    assign ref_gnt   = ref_gnt_q;
    assign pre_gnt   = pre_gnt_q;
    assign cas_gnt   = cas_gnt_q;
    assign act_gnt   = act_gnt_q;
    assign cmd_valid = ref_gnt_q | pre_gnt_q | cas_gnt_q | act_gnt_q;
    assign cmd_code  = code_q;
    assign faw_count = faw_cnt_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_ddr_cmd_arbiter.sv
// Bench for ddr_cmd_arbiter: directed scenarios plus random requesters, all
// checked against a grant-time model built from the timing rules.
module tb_ddr_cmd_arbiter;
    localparam int T_RRD = 4;
    localparam int T_FAW = 16;
    localparam int T_CCD = 4;
    localparam int T_WTR = 8;
    localparam int T_RTW = 10;

    logic       clock_t = 1'b0;
    logic       reset_n = 1'b0;
    logic       ref_req = 1'b0, pre_req = 1'b0, cas_req = 1'b0, act_req = 1'b0;
    logic [1:0] cas_rw  = 2'b01;
    logic       ref_gnt, pre_gnt, cas_gnt, act_gnt, cmd_valid, busy;
    logic [2:0] cmd_code, faw_count;

    always #5 clock_t = ~clock_t;

    ddr_cmd_arbiter #(
        .T_RRD(T_RRD), .T_FAW(T_FAW), .T_CCD(T_CCD), .T_WTR(T_WTR), .T_RTW(T_RTW)
    ) dut (
        .clock_t(clock_t), .reset_n(reset_n),
        .ref_req(ref_req), .pre_req(pre_req), .cas_req(cas_req), .cas_rw(cas_rw),
        .act_req(act_req),
        .ref_gnt(ref_gnt), .pre_gnt(pre_gnt), .cas_gnt(cas_gnt), .act_gnt(act_gnt),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .faw_count(faw_count), .busy(busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: grant times, not counters.
    int         now;
    int         last_act, last_cas, last_rd, last_wr;
    int         act_t[$];
    logic [3:0] e_gnt;          // {ref, pre, cas, act}
    logic [2:0] e_code, e_faw;
    logic       e_busy;
    int         log_code[64];
    int         log_faw[64];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d (t=%0d)", tag, obs, exp, now);
        end
    endtask

    function automatic void model_reset();
        now = 0;
        last_act = -1000; last_cas = -1000; last_rd = -1000; last_wr = -1000;
        act_t.delete();
        e_gnt = 4'b0; e_code = 3'd0; e_faw = 3'd0; e_busy = 1'b0;
        for (int i = 0; i < 64; i++) begin
            log_code[i] = 0;
            log_faw[i]  = 0;
        end
    endfunction

    function automatic int acts_since(input int lo);
        int n = 0;
        foreach (act_t[i]) if (act_t[i] >= lo) n++;
        return n;
    endfunction

    // Decide the grant that appears in cycle now+1 from the current inputs.
    function automatic void model_decide();
        int t;
        bit act_ok, rd_ok, wr_ok;
        logic [3:0] g;
        logic [2:0] c;
        t = now + 1;
        g = 4'b0;
        c = 3'd0;
        while (act_t.size() > 0 && act_t[0] < t - T_FAW) void'(act_t.pop_front());
        act_ok = (t - last_act >= T_RRD) && (acts_since(t - T_FAW + 1) < 4);
        rd_ok  = (cas_rw == 2'b01) && (t - last_cas >= T_CCD) && (t - last_wr >= T_WTR);
        wr_ok  = (cas_rw == 2'b10) && (t - last_cas >= T_CCD) && (t - last_rd >= T_RTW);
        if (ref_req && !e_gnt[3]) begin
            g = 4'b1000; c = 3'd5;
        end else if (pre_req && !e_gnt[2]) begin
            g = 4'b0100; c = 3'd4;
        end else if (cas_req && !e_gnt[1] && (rd_ok || wr_ok)) begin
            g = 4'b0010; last_cas = t;
            if (rd_ok) begin c = 3'd2; last_rd = t; end
            else       begin c = 3'd3; last_wr = t; end
        end else if (act_req && !e_gnt[0] && act_ok) begin
            g = 4'b0001; c = 3'd1; last_act = t; act_t.push_back(t);
        end
        e_gnt  = g;
        e_code = c;
        e_faw  = 3'(acts_since(t - T_FAW + 1));
        e_busy = (t - last_act < T_RRD - 1) || (t - last_cas < T_CCD - 1) ||
                 (t - last_wr < T_WTR - 1) || (t - last_rd < T_RTW - 1) || (e_faw != 3'd0);
    endfunction

    task automatic tick();
        model_decide();
        @(posedge clock_t);
        #1;
        now++;
        if (now < 64) begin
            log_code[now] = int'(cmd_code);
            log_faw[now]  = int'(faw_count);
        end
        chk("ref_gnt",   ref_gnt,   e_gnt[3]);
        chk("pre_gnt",   pre_gnt,   e_gnt[2]);
        chk("cas_gnt",   cas_gnt,   e_gnt[1]);
        chk("act_gnt",   act_gnt,   e_gnt[0]);
        chk("cmd_valid", cmd_valid, |e_gnt);
        chk("cmd_code",  cmd_code,  e_code);
        chk("faw_count", faw_count, e_faw);
        chk("busy",      busy,      e_busy);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_gnt"},  {ref_gnt, pre_gnt, cas_gnt, act_gnt}, 0);
        chk({tag, "_valid"}, cmd_valid, 0);
        chk({tag, "_code"},  cmd_code,  0);
        chk({tag, "_faw"},   faw_count, 0);
        chk({tag, "_busy"},  busy,      0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        ref_req = 1'b0; pre_req = 1'b0; cas_req = 1'b0; act_req = 1'b0;
        cas_rw  = 2'b01;
        repeat (2) @(posedge clock_t);
        #1;
        model_reset();
        check_all_zero("reset");
        reset_n = 1'b1;
    endtask

    function automatic logic [1:0] pick_rw();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return 2'b11;
        return (r < 5) ? 2'b01 : 2'b10;
    endfunction

    // Requesters drop req in the cycle after the one in which gnt was seen.
    task automatic run_agents(input int n, input bit rnd);
        logic [3:0] pg;
        for (int i = 0; i < n; i++) begin
            pg = e_gnt;
            tick();
            if (pg[3]) ref_req = 1'b0;
            if (pg[2]) pre_req = 1'b0;
            if (pg[1]) cas_req = 1'b0;
            if (pg[0]) act_req = 1'b0;
            if (rnd) begin
                if (!ref_req && !pg[3] && $urandom_range(0, 15) == 0) ref_req = 1'b1;
                if (!pre_req && !pg[2] && $urandom_range(0, 7) == 0)  pre_req = 1'b1;
                if (!cas_req && !pg[1] && $urandom_range(0, 2) == 0) begin
                    cas_req = 1'b1;
                    cas_rw  = pick_rw();
                end else if (cas_req && $urandom_range(0, 15) == 0) begin
                    cas_rw = pick_rw();
                end
                if (!act_req && !pg[0] && $urandom_range(0, 2) == 0) act_req = 1'b1;
            end
        end
    endtask

    function automatic int first_at(input int code, input int from);
        for (int t = from; t < 64; t++) if (log_code[t] == code) return t;
        return -1;
    endfunction

    function automatic int count_code(input int code);
        int n = 0;
        for (int t = 1; t < 64; t++) if (log_code[t] == code) n++;
        return n;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();

        // ACT spacing with act_req held: grants at 1,5,9,13,17 relative to release.
        do_reset();
        act_req = 1'b1;
        repeat (18) tick();
        act_req = 1'b0;
        chk("act0", first_at(1, 1), 1);
        chk("act1", first_at(1, 2), 5);
        chk("act2", first_at(1, 6), 9);
        chk("act3", first_at(1, 10), 13);
        chk("act5_faw", first_at(1, 14), 17);
        chk("faw_at_12", log_faw[12], 3);
        for (int t = 13; t <= 16; t++) chk("faw_full", log_faw[t], 4);

        // All four requests together resolve REF, PRE, CAS(RD), ACT.
        do_reset();
        ref_req = 1'b1; pre_req = 1'b1; cas_req = 1'b1; act_req = 1'b1; cas_rw = 2'b01;
        run_agents(8, 1'b0);
        chk("prio1", log_code[1], 5);
        chk("prio2", log_code[2], 4);
        chk("prio3", log_code[3], 2);
        chk("prio4", log_code[4], 1);
        chk("prio_idle", log_code[5], 0);

        // READ then WRITE: write held off for T_RTW.
        do_reset();
        cas_req = 1'b1; cas_rw = 2'b01;
        tick();
        cas_rw = 2'b10;
        repeat (12) tick();
        cas_req = 1'b0;
        chk("rtw_rd", log_code[1], 2);
        chk("rtw_wr", first_at(3, 2), 11);

        // WRITE then READ: read held off for T_WTR.
        do_reset();
        cas_req = 1'b1; cas_rw = 2'b10;
        tick();
        cas_rw = 2'b01;
        repeat (10) tick();
        cas_req = 1'b0;
        chk("wtr_wr", log_code[1], 3);
        chk("wtr_rd", first_at(2, 2), 9);

        // CAS blocked by tCCD does not block an eligible ACT.
        do_reset();
        cas_req = 1'b1; cas_rw = 2'b01;
        repeat (2) tick();
        act_req = 1'b1;
        run_agents(5, 1'b0);
        chk("blk_cas0", log_code[1], 2);
        chk("blk_act", log_code[3], 1);
        chk("blk_gap", log_code[4], 0);
        chk("blk_cas1", log_code[5], 2);

        // Req still high during its grant cycle yields one grant only.
        do_reset();
        ref_req = 1'b1;
        repeat (2) tick();
        ref_req = 1'b0;
        repeat (3) tick();
        chk("single_ref", count_code(5), 1);

        // cas_rw=11 is never granted and does not block ACT.
        do_reset();
        cas_req = 1'b1; cas_rw = 2'b11; act_req = 1'b1;
        run_agents(20, 1'b0);
        cas_req = 1'b0;
        chk("rw11_rd", count_code(2), 0);
        chk("rw11_wr", count_code(3), 0);
        chk("rw11_act", log_code[1], 1);

        // Asynchronous reset while act_gnt is high.
        do_reset();
        act_req = 1'b1;
        tick();
        chk("pre_rst_act", act_gnt, 1);
        reset_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        #1;
        reset_n = 1'b1;
        tick();
        chk("post_rst_act", act_gnt, 1);
        chk("post_rst_code", cmd_code, 1);
        act_req = 1'b0;

        // Random traffic against the model.
        do_reset();
        run_agents(3000, 1'b1);
        ref_req = 1'b0; pre_req = 1'b0; cas_req = 1'b0; act_req = 1'b0;
        run_agents(30, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
